// File: rtl/uart_pkg.sv
// Shared UART types and frame constants for the PHY and its bit timers.
package uart_pkg;

   localparam int         DATA_BITS = 8;
   localparam int         TIMER_W   = 16;
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_IDLE = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick is high while the count has reached zero.
module uart_bit_timer
   import uart_pkg::*;
(
   input  logic               clk,
   input  logic               rstn,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic               tick
);

   logic [TIMER_W-1:0] cnt_r;

   // Count down from the loaded value and park at zero until reloaded.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= {TIMER_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {TIMER_W{1'b0}}) begin
         cnt_r <= cnt_r - {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tick = (cnt_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART PHY: independent transmitter and receiver with a one-byte RX holding register.
module uart_phy
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       uart_txd,
   input  logic       uart_rxd,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   // Timer reload values: a full bit, and half a bit to land mid-bit after the start edge.
   localparam logic [TIMER_W-1:0] BIT_LD  = TIMER_W'(BAUD_DIV - 1);
   localparam logic [TIMER_W-1:0] HALF_LD = TIMER_W'((BAUD_DIV / 2) - 1);

   // ---------------- transmitter ----------------
   tx_state_t  tx_state_r;
   logic [7:0] tx_shift_r;
   logic [2:0] tx_bit_r;
   logic       txd_r;
   logic       tx_ready_r;
   logic       tx_accept_s;
   logic       tx_load_s;
   logic       tx_tick_s;

   // Acceptance and timer reload: restart the bit period on accept and on every bit boundary.
   always_comb begin
      tx_accept_s = tx_valid && tx_ready_r;
      tx_load_s   = tx_accept_s || ((tx_state_r != TX_IDLE) && tx_tick_s);
   end

   uart_bit_timer u_tx_timer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (tx_load_s),
      .load_val (BIT_LD),
      .tick     (tx_tick_s)
   );

   // TX state machine; the line and ready are registered so they change exactly on bit boundaries.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_state_r <= TX_IDLE;
         tx_shift_r <= 8'h00;
         tx_bit_r   <= 3'd0;
         txd_r      <= 1'b1;
         tx_ready_r <= 1'b1;
      end else begin
         case (tx_state_r)
            TX_IDLE: begin
               txd_r <= 1'b1;
               if (tx_accept_s) begin
                  tx_shift_r <= tx_data;
                  txd_r      <= 1'b0;
                  tx_ready_r <= 1'b0;
                  tx_state_r <= TX_START;
               end
            end
            TX_START: begin
               if (tx_tick_s) begin
                  txd_r      <= tx_shift_r[0];
                  tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                  tx_bit_r   <= 3'd0;
                  tx_state_r <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tx_tick_s) begin
                  if (tx_bit_r == LAST_BIT) begin
                     txd_r      <= 1'b1;
                     tx_state_r <= TX_STOP;
                  end else begin
                     txd_r      <= tx_shift_r[0];
                     tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                     tx_bit_r   <= tx_bit_r + 3'd1;
                  end
               end
            end
            TX_STOP: begin
               if (tx_tick_s) begin
                  tx_ready_r <= 1'b1;
                  tx_state_r <= TX_IDLE;
               end
            end
            default: begin
               txd_r      <= 1'b1;
               tx_ready_r <= 1'b1;
               tx_state_r <= TX_IDLE;
            end
         endcase
      end
   end

   assign uart_txd = txd_r;
   assign tx_ready = tx_ready_r;

   // ---------------- receiver ----------------
   rx_state_t          rx_state_r;
   logic               sync1_r;
   logic               sync2_r;
   logic               rxd_prev_r;
   logic [7:0]         rx_shift_r;
   logic [2:0]         rx_bit_r;
   logic               rx_valid_r;
   logic [7:0]         rx_data_r;
   logic               rx_overrun_r;
   logic               rx_frame_err_r;
   logic               rx_fall_s;
   logic               rx_load_s;
   logic [TIMER_W-1:0] rx_load_val_s;
   logic               rx_tick_s;

   // Two-flop synchronizer on the asynchronous line plus a delayed copy for edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_r    <= 1'b1;
         sync2_r    <= 1'b1;
         rxd_prev_r <= 1'b1;
      end else begin
         sync1_r    <= uart_rxd;
         sync2_r    <= sync1_r;
         rxd_prev_r <= sync2_r;
      end
   end

   // Timer reload: half a bit after the start edge, then whole bits between mid-bit samples.
   always_comb begin
      rx_fall_s     = rxd_prev_r && !sync2_r;
      rx_load_s     = 1'b0;
      rx_load_val_s = BIT_LD;
      case (rx_state_r)
         RX_IDLE: begin
            if (rx_fall_s) begin
               rx_load_s     = 1'b1;
               rx_load_val_s = HALF_LD;
            end else begin
               rx_load_s     = 1'b0;
            end
         end
         RX_START, RX_DATA: begin
            if (rx_tick_s) begin
               rx_load_s = 1'b1;
            end else begin
               rx_load_s = 1'b0;
            end
         end
         default: begin
            rx_load_s = 1'b0;
         end
      endcase
   end

   uart_bit_timer u_rx_timer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (rx_load_s),
      .load_val (rx_load_val_s),
      .tick     (rx_tick_s)
   );

   // RX state machine with holding register, handshake and one-cycle error pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_state_r     <= RX_IDLE;
         rx_shift_r     <= 8'h00;
         rx_bit_r       <= 3'd0;
         rx_valid_r     <= 1'b0;
         rx_data_r      <= 8'h00;
         rx_overrun_r   <= 1'b0;
         rx_frame_err_r <= 1'b0;
      end else begin
         rx_overrun_r   <= 1'b0;
         rx_frame_err_r <= 1'b0;
         if (rx_valid_r && rx_ready) begin
            rx_valid_r <= 1'b0;
         end
         case (rx_state_r)
            RX_IDLE: begin
               if (rx_fall_s) begin
                  rx_state_r <= RX_START;
               end
            end
            RX_START: begin
               if (rx_tick_s) begin
                  rx_bit_r   <= 3'd0;
                  rx_state_r <= sync2_r ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (rx_tick_s) begin
                  rx_shift_r <= {sync2_r, rx_shift_r[7:1]};
                  rx_bit_r   <= rx_bit_r + 3'd1;
                  if (rx_bit_r == LAST_BIT) begin
                     rx_state_r <= RX_STOP;
                  end
               end
            end
            RX_STOP: begin
               if (rx_tick_s) begin
                  if (!sync2_r) begin
                     rx_frame_err_r <= 1'b1;
                     rx_state_r     <= RX_WAIT_IDLE;
                  end else if (!rx_valid_r || rx_ready) begin
                     rx_data_r  <= rx_shift_r;
                     rx_valid_r <= 1'b1;
                     rx_state_r <= RX_IDLE;
                  end else begin
                     rx_overrun_r <= 1'b1;
                     rx_state_r   <= RX_IDLE;
                  end
               end
            end
            RX_WAIT_IDLE: begin
               if (sync2_r) begin
                  rx_state_r <= RX_IDLE;
               end
            end
            default: begin
               rx_state_r <= RX_IDLE;
            end
         endcase
      end
   end

   assign rx_valid     = rx_valid_r;
   assign rx_data      = rx_data_r;
   assign rx_overrun   = rx_overrun_r;
   assign rx_frame_err = rx_frame_err_r;

endmodule
